// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : miniRV instruction fetch: PC, ROM address, IF/ID register,
//            EX-stage redirect resolution and hazard stall handling.
//            Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   parameter int          CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [31:0]       irom_pc,
   input  logic [31:0]       irom_inst,
   input  logic              stall,
   input  logic              ex_valid,
   input  logic [1:0]        ex_npc_op,
   input  logic              ex_br_true,
   input  logic [31:0]       ex_pc,
   input  logic [31:0]       ex_imm,
   input  logic [31:0]       ex_alu_c,
   output logic              redirect,
`ifdef FETCH_PERF_CNT_EN
   output logic [CNT_W-1:0]  perf_fetched,
   output logic [CNT_W-1:0]  perf_flushed,
   output logic [CNT_W-1:0]  perf_stalled,
`endif
   output logic              id_valid,
   output logic [31:0]       id_pc,
   output logic [31:0]       id_pc4,
   output logic [31:0]       id_inst
);

   localparam logic [1:0]  c_npc_jal    = 2'b01;
   localparam logic [1:0]  c_npc_branch = 2'b10;
   localparam logic [1:0]  c_npc_jalr   = 2'b11;
   localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic        r_id_valid;
   logic [31:0] r_id_pc;
   logic [31:0] r_id_pc4;
   logic [31:0] r_id_inst;

   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_nxt;
   logic        w_id_valid_nxt;
   logic [31:0] w_id_pc_nxt;
   logic [31:0] w_id_pc4_nxt;
   logic [31:0] w_id_inst_nxt;
   logic        w_do_advance;
   logic        w_do_flush;
   logic        w_do_stall;

   assign w_pc_plus4 = r_pc + 32'd4;

   always_comb begin
      w_redirect = 1'b0;
      w_target   = ex_pc + ex_imm;
      if (ex_valid) begin
         case (ex_npc_op)
            c_npc_jal:    w_redirect = 1'b1;
            c_npc_branch: w_redirect = ex_br_true;
            c_npc_jalr: begin
               w_redirect = 1'b1;
               w_target   = ex_alu_c;
            end
            default:      w_redirect = 1'b0;
         endcase
      end
      w_target = w_target & c_align_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Redirect outranks stall: the held ID instruction is younger than EX and dies.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_id_valid_nxt = r_id_valid;
      w_id_pc_nxt    = r_id_pc;
      w_id_pc4_nxt   = r_id_pc4;
      w_id_inst_nxt  = r_id_inst;
      w_do_advance   = 1'b0;
      w_do_flush     = 1'b0;
      w_do_stall     = 1'b0;
      case (r_state)
         BOOT: begin
            w_state_nxt    = RUN;
            w_pc_nxt       = RESET_PC;
            w_id_valid_nxt = 1'b0;
            w_id_pc_nxt    = 32'd0;
            w_id_pc4_nxt   = 32'd0;
            w_id_inst_nxt  = NOP_INST;
         end
         RUN: begin
            w_state_nxt = RUN;
            if (w_redirect) begin
               w_do_flush     = 1'b1;
               w_pc_nxt       = w_target;
               w_id_valid_nxt = 1'b0;
               w_id_pc_nxt    = 32'd0;
               w_id_pc4_nxt   = 32'd0;
               w_id_inst_nxt  = NOP_INST;
            end else if (stall) begin
               w_do_stall = 1'b1;
            end else begin
               w_do_advance   = 1'b1;
               w_pc_nxt       = w_pc_plus4;
               w_id_valid_nxt = 1'b1;
               w_id_pc_nxt    = r_pc;
               w_id_pc4_nxt   = w_pc_plus4;
               w_id_inst_nxt  = irom_inst;
            end
         end
         default: begin
            w_state_nxt = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_id_valid <= 1'b0;
         r_id_pc    <= 32'd0;
         r_id_pc4   <= 32'd0;
         r_id_inst  <= NOP_INST;
      end else begin
         r_pc       <= w_pc_nxt;
         r_id_valid <= w_id_valid_nxt;
         r_id_pc    <= w_id_pc_nxt;
         r_id_pc4   <= w_id_pc4_nxt;
         r_id_inst  <= w_id_inst_nxt;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt_fetched;
   logic [CNT_W-1:0] r_cnt_flushed;
   logic [CNT_W-1:0] r_cnt_stalled;

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_fetched <= '0;
         r_cnt_flushed <= '0;
         r_cnt_stalled <= '0;
      end else begin
         if (w_do_advance && (r_cnt_fetched != '1)) begin
            r_cnt_fetched <= r_cnt_fetched + c_cnt_one;
         end
         if (w_do_flush && (r_cnt_flushed != '1)) begin
            r_cnt_flushed <= r_cnt_flushed + c_cnt_one;
         end
         if (w_do_stall && (r_cnt_stalled != '1)) begin
            r_cnt_stalled <= r_cnt_stalled + c_cnt_one;
         end
      end
   end

   assign perf_fetched = r_cnt_fetched;
   assign perf_flushed = r_cnt_flushed;
   assign perf_stalled = r_cnt_stalled;
`else
   logic w_unused_perf;
   assign w_unused_perf = w_do_advance ^ w_do_flush ^ w_do_stall ^ (CNT_W > 0);
`endif

   assign irom_pc  = r_pc;
   assign redirect = w_redirect;
   assign id_valid = r_id_valid;
   assign id_pc    = r_id_pc;
   assign id_pc4   = r_id_pc4;
   assign id_inst  = r_id_inst;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit: directed sequences plus
//            randomized traffic against a behavioural model. Perf counter
//            checks are included when FETCH_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] irom_pc;
   logic [31:0] irom_inst;
   logic        stall;
   logic        ex_valid;
   logic [1:0]  ex_npc_op;
   logic        ex_br_true;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic [31:0] ex_alu_c;
   logic        redirect;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic [31:0] id_inst;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushed;
   logic [31:0] perf_stalled;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .NOP_INST (32'h0000_0013),
      .CNT_W    (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .irom_pc      (irom_pc),
      .irom_inst    (irom_inst),
      .stall        (stall),
      .ex_valid     (ex_valid),
      .ex_npc_op    (ex_npc_op),
      .ex_br_true   (ex_br_true),
      .ex_pc        (ex_pc),
      .ex_imm       (ex_imm),
      .ex_alu_c     (ex_alu_c),
      .redirect     (redirect),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetched (perf_fetched),
      .perf_flushed (perf_flushed),
      .perf_stalled (perf_stalled),
`endif
      .id_valid     (id_valid),
      .id_pc        (id_pc),
      .id_pc4       (id_pc4),
      .id_inst      (id_inst)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] addr);
      return 32'h1000_0000 + (addr >> 2);
   endfunction

   assign irom_inst = rom_word(irom_pc);

   // Control-flow rule: jal, jalr and taken branches redirect; target word-aligned.
   function automatic logic exp_taken();
      if (!ex_valid) return 1'b0;
      return (ex_npc_op == 2'd1) || (ex_npc_op == 2'd3) ||
             (ex_npc_op == 2'd2 && ex_br_true);
   endfunction

   function automatic logic [31:0] exp_target();
      logic [31:0] t;
      t = (ex_npc_op == 2'd3) ? ex_alu_c : (ex_pc + ex_imm);
      return {t[31:2], 2'b00};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a PC, a record of the last fetched instruction, event tallies.
   logic        m_boot     = 1'b1;
   logic [31:0] m_pc       = 32'h0;
   logic        m_id_valid = 1'b0;
   logic [31:0] m_id_pc    = 32'h0;
   logic [31:0] m_id_pc4   = 32'h0;
   logic [31:0] m_id_inst  = 32'h13;
   longint      m_fetched  = 0;
   longint      m_flushed  = 0;
   longint      m_stalled  = 0;

   task automatic model_bubble();
      m_id_valid = 1'b0;
      m_id_pc    = 32'h0;
      m_id_pc4   = 32'h0;
      m_id_inst  = 32'h13;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_boot = 1'b1;
         m_pc   = 32'h0;
         model_bubble();
         m_fetched = 0;
         m_flushed = 0;
         m_stalled = 0;
      end else if (m_boot) begin
         m_boot = 1'b0;
         model_bubble();
      end else if (exp_taken()) begin
         m_pc = exp_target();
         model_bubble();
         m_flushed++;
      end else if (stall) begin
         m_stalled++;
      end else begin
         m_id_valid = 1'b1;
         m_id_pc    = m_pc;
         m_id_pc4   = m_pc + 32'd4;
         m_id_inst  = rom_word(m_pc);
         m_pc       = m_pc + 32'd4;
         m_fetched++;
      end
   end

   function automatic logic [31:0] sat32(input longint v);
      return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   always @(negedge clk) begin
      check("cmp_irom_pc",  irom_pc,         m_pc);
      check("cmp_redirect", {31'd0, redirect}, {31'd0, exp_taken()});
      check("cmp_id_valid", {31'd0, id_valid}, {31'd0, m_id_valid});
      check("cmp_id_pc",    id_pc,           m_id_pc);
      check("cmp_id_pc4",   id_pc4,          m_id_pc4);
      check("cmp_id_inst",  id_inst,         m_id_inst);
`ifdef FETCH_PERF_CNT_EN
      check("cmp_perf_fetched", perf_fetched, sat32(m_fetched));
      check("cmp_perf_flushed", perf_flushed, sat32(m_flushed));
      check("cmp_perf_stalled", perf_stalled, sat32(m_stalled));
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_idle();
      ex_valid   = 1'b0;
      ex_npc_op  = 2'd0;
      ex_br_true = 1'b0;
      ex_pc      = 32'h0;
      ex_imm     = 32'h0;
      ex_alu_c   = 32'h0;
   endtask

   task automatic ex_set(input logic [1:0] op, input logic br, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] alu);
      ex_valid   = 1'b1;
      ex_npc_op  = op;
      ex_br_true = br;
      ex_pc      = pc;
      ex_imm     = imm;
      ex_alu_c   = alu;
   endtask

   task automatic restart();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      ex_idle();
      step();
      step();
      rst_n = 1'b1;

      // Boot, then sequential fetch
      check("boot_id_valid", {31'd0, id_valid}, 32'd0);
      check("boot_irom_pc",  irom_pc, 32'h0);
      check("boot_id_inst",  id_inst, 32'h13);
      step();
      check("run0_id_valid", {31'd0, id_valid}, 32'd0);
      check("run0_irom_pc",  irom_pc, 32'h0);
      step();
      check("f0_id_pc",   id_pc,   32'h0);
      check("f0_id_inst", id_inst, 32'h1000_0000);
      check("f0_id_pc4",  id_pc4,  32'h4);
      step();
      check("f1_id_pc",   id_pc,   32'h4);
      check("f1_id_inst", id_inst, 32'h1000_0001);
      step();
      check("f2_id_pc",   id_pc,   32'h8);
      check("f2_id_inst", id_inst, 32'h1000_0002);
      check("f2_irom_pc", irom_pc, 32'hC);

      // Stall holds PC and IF/ID
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_irom_pc", irom_pc, 32'hC);
         check("stall_id_pc",   id_pc,   32'h8);
         check("stall_id_inst", id_inst, 32'h1000_0002);
      end
      stall = 1'b0;
      step();
      check("unstall_id_pc",   id_pc,   32'hC);
      check("unstall_id_inst", id_inst, 32'h1000_0003);

      // jal
      ex_set(2'd1, 1'b0, 32'h20, 32'h40, 32'h0);
      #1;
      check("jal_redirect", {31'd0, redirect}, 32'd1);
      step();
      ex_idle();
      check("jal_irom_pc",  irom_pc, 32'h60);
      check("jal_id_valid", {31'd0, id_valid}, 32'd0);
      check("jal_id_inst",  id_inst, 32'h13);

      // jalr with misaligned ALU result, then not-taken branch
      ex_set(2'd3, 1'b0, 32'h0, 32'h0, 32'h0000_0107);
      step();
      check("jalr_irom_pc", irom_pc, 32'h104);
      ex_set(2'd2, 1'b0, 32'h50, 32'h10, 32'h0);
      #1;
      check("bnt_redirect", {31'd0, redirect}, 32'd0);
      step();
      ex_idle();
      check("bnt_irom_pc",  irom_pc, 32'h108);
      check("bnt_id_pc",    id_pc,   32'h104);
      check("bnt_id_inst",  id_inst, 32'h1000_0041);

      // Taken branch while stalled: redirect wins
      stall = 1'b1;
      ex_set(2'd2, 1'b1, 32'h100, 32'hFFFF_FFF8, 32'h0);
      step();
      stall = 1'b0;
      ex_idle();
      check("bst_irom_pc",  irom_pc, 32'hF8);
      check("bst_id_valid", {31'd0, id_valid}, 32'd0);
      check("bst_id_inst",  id_inst, 32'h13);

      // PC wrap at top of address space
      ex_set(2'd3, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFE);
      step();
      ex_idle();
      check("wrap_pre_pc", irom_pc, 32'hFFFF_FFFC);
      step();
      check("wrap_irom_pc", irom_pc, 32'h0);
      check("wrap_id_pc4",  id_pc4,  32'h0);

      // Mid-run asynchronous reset, even with stall and redirect asserted
      stall = 1'b1;
      ex_set(2'd1, 1'b0, 32'h300, 32'h4, 32'h0);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_irom_pc",  irom_pc, 32'h0);
      check("arst_id_valid", {31'd0, id_valid}, 32'd0);
      check("arst_id_inst",  id_inst, 32'h13);
      step();
      stall = 1'b0;
      ex_idle();
      rst_n = 1'b1;

`ifdef FETCH_PERF_CNT_EN
      step();
      for (int i = 0; i < 10; i++) step();
      stall = 1'b1;
      step();
      step();
      stall = 1'b0;
      ex_set(2'd1, 1'b0, 32'h0, 32'h80, 32'h0);
      step();
      ex_idle();
      check("perf_fetched_10", perf_fetched, 32'd10);
      check("perf_flushed_1",  perf_flushed, 32'd1);
      check("perf_stalled_2",  perf_stalled, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("perf_rst_fetched", perf_fetched, 32'd0);
      check("perf_rst_flushed", perf_flushed, 32'd0);
      check("perf_rst_stalled", perf_stalled, 32'd0);
      step();
      rst_n = 1'b1;
`endif

      // Randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         stall = ($urandom_range(0, 3) == 0);
         ex_valid   = ($urandom_range(0, 2) == 0);
         ex_npc_op  = 2'($urandom_range(0, 3));
         ex_br_true = 1'($urandom_range(0, 1));
         ex_pc      = $urandom;
         ex_imm     = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 255)) - 128);
         ex_alu_c   = $urandom;
         if ($urandom_range(0, 249) == 0) begin
            #2;
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end
      ex_idle();
      stall = 1'b0;
      restart();
      step();
      step();
      check("final_id_pc", id_pc, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
